// File: rtl/io_input_reader_if.sv
// CPU IO bus as seen by a memory-mapped peripheral: one-cycle access strobe,
// word address, store data and combinational load data.
`timescale 1ns/1ps
interface io_input_reader_if;
  logic        io_en;
  logic        io_we;
  logic [11:0] io_addr;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;

  modport master (
    output io_en,
    output io_we,
    output io_addr,
    output io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_en,
    input  io_we,
    input  io_addr,
    input  io_write_data,
    output io_read_data
  );
endinterface

// File: rtl/io_input_reader.sv
// Switch/button input port on the CPU IO bus: two-flop synchronizers, a shared
// tick-based debouncer, sticky button-press pending bits, and read-back decode.
`timescale 1ns/1ps
module io_input_reader #(
  parameter logic [11:0] SW_ADDR    = 12'h070,
  parameter logic [11:0] BTN_ADDR   = 12'h078,
  parameter int          DEB_CYCLES = 100000,
  parameter int          CNT_W      = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  io_input_reader_if.slave   bus,
  input  logic [23:0]        sw,
  input  logic [4:0]         button
);

  localparam int NB = 29;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NB-1:0]    raw_in;
  logic [NB-1:0]    in_s1;
  logic [NB-1:0]    in_s2;
  logic [NB-1:0]    samp;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    stable_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [4:0]       pending;
  logic [4:0]       pending_nxt;
  logic [4:0]       rise;
  logic [4:0]       clr;
  logic             rd_hit;
  logic             rd_btn;
  logic             wr_btn;
  logic             unused_wdata;

  // Buttons occupy the top five bits so one debouncer covers everything.
  assign raw_in = {button, sw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1 <= '0;
      in_s2 <= '0;
    end else begin
      in_s1 <= raw_in;
      in_s2 <= in_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (tick_cnt == CNT_MAX);

  // A bit follows the synchronized input only when two consecutive ticks agree.
  always_comb begin
    stable_nxt = stable;
    if (tick) begin
      stable_nxt = (~(in_s2 ^ samp) & in_s2) | ((in_s2 ^ samp) & stable);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp   <= '0;
      stable <= '0;
    end else begin
      if (tick) begin
        samp <= in_s2;
      end
      stable <= stable_nxt;
    end
  end

  assign rise   = stable_nxt[28:24] & ~stable[28:24];
  assign rd_hit = bus.io_en & ~bus.io_we;
  assign rd_btn = rd_hit & (bus.io_addr == BTN_ADDR);
  assign wr_btn = bus.io_en & bus.io_we & (bus.io_addr == BTN_ADDR);

  // Clear is applied before set so a press on the clearing edge is kept.
  always_comb begin
    clr = '0;
    if (rd_btn) begin
      clr = '1;
    end else if (wr_btn) begin
      clr = bus.io_write_data[12:8];
    end
    pending_nxt = (pending & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_comb begin
    bus.io_read_data = '0;
    if (rd_hit) begin
      if (bus.io_addr == SW_ADDR) begin
        bus.io_read_data = {8'b0, stable[23:0]};
      end else if (bus.io_addr == BTN_ADDR) begin
        bus.io_read_data = {19'b0, pending, 3'b0, stable[28:24]};
      end
    end
  end

  assign unused_wdata = ^{bus.io_write_data[31:13], bus.io_write_data[7:0]};

endmodule

// File: doc/io_input_reader.md
# io_input_reader

Memory-mapped input peripheral on the CPU IO bus, the read-side counterpart of the seven-segment write port. It synchronizes and debounces the 24 board switches and 5 push-buttons, latches button press events in sticky pending bits, and returns switch/button state on CPU loads from two fixed IO addresses. It sits beside the display driver on the shared `io_en`/`io_addr` decode, and its `io_read_data` feeds the CPU load-data mux.

## Interface
- `SW_ADDR`, 12'h070, IO address of the switch register.
- `BTN_ADDR`, 12'h078, IO address of the button register.
- `DEB_CYCLES`, 100000, debounce sample period in clk cycles (1 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, 17, width of the sample-tick counter; must hold `DEB_CYCLES-1`.
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_en` in 1: IO access strobe, valid for one cycle per access.
- `io_we` in 1: 1 = store, 0 = load.
- `io_addr` in 12: IO word address.
- `io_write_data` in 32: store data, used only for pending-bit clear.
- `sw` in 24: raw asynchronous switch levels.
- `button` in 5: raw asynchronous button levels, 1 = pressed.
- `io_read_data` out 32: load data, combinational.

## Operation
- Synchronizer: every `sw`/`button` bit passes through two flops (`*_s1` → `*_s2`), reset 0.
- Tick: counter 0..`DEB_CYCLES-1`, wraps to 0. `tick` = 1 for exactly one cycle when the count equals `DEB_CYCLES-1`. Counter resets to 0.
- Debounce is shared across all 29 bits. On `tick`: `samp <= s2`. If `s2 == samp`, then `stable <= s2`, per bit. A bit therefore needs two consecutive equal tick samples before `stable` follows it. `samp` and `stable` reset to 0.
- Press event: `rise[i]` = the `stable` button bit transitions 0→1 at this edge. `pending[i]` is set on the same edge. Release (1→0) creates no event.
- Read data is valid when `io_en && !io_we`:
  - `SW_ADDR` returns {8'b0, `sw_stable[23:0]`}.
  - `BTN_ADDR` returns {19'b0, `pending[4:0]`, 3'b0, `btn_stable[4:0]`}.
  - Any other address, or no load, returns 32'b0.
- Read-to-clear: a load from `BTN_ADDR` clears all pending bits at the end of that cycle. The returned value is the pre-clear value.
- Write-1-to-clear: a store to `BTN_ADDR` clears `pending[i]` wherever `io_write_data[8+i]` = 1. Other bits are unaffected.
- Stores to `SW_ADDR` or to other addresses have no effect.
- Simultaneous set and clear on the same bit in the same edge: set wins, so `pending[i]` stays 1 and no press is lost.
- Loads from `SW_ADDR` never alter state.

## Timing
- Reset values: all flops are 0 and `io_read_data` = 0. After reset, a switch held at 1 appears in `stable` only after two ticks.
- `io_read_data` is combinational from `io_en`, `io_we`, `io_addr` and registers. It has zero-cycle latency and is stable for the whole access cycle.
- Input to `stable` latency, for a clean input change at edge t: `s2` updates at t+2, then `stable` updates on the second tick after that. Total ≈ 2 + `DEB_CYCLES` … 2 + 2·`DEB_CYCLES` cycles.
- Glitches shorter than one tick period that are not present at two consecutive ticks never reach `stable`.
- `pending` sets on the same edge as the `stable` rise. It is visible to a load in the next cycle.
- Reset asserted mid-operation clears counter, synchronizers, `stable` and `pending` immediately; no event survives reset.

## Test plan
All scenarios use `DEB_CYCLES`=4.
- Reset: hold `rst_n`=0 with `sw`=24'hFFFFFF, then release. A load from `SW_ADDR` returns 0 until two ticks have elapsed, then 32'h00FFFFFF. A load from `BTN_ADDR` returns 0.
- Debounce: `button[2]` pulses high for 3 cycles positioned so that only one tick samples it high. `btn_stable` and `pending` stay 0. A 20-cycle press gives `BTN_ADDR` read 32'h0000_0404 while held.
- Read-to-clear: after a `button[0]` press and release, the first load from `BTN_ADDR` returns 32'h0000_0100 and the second returns 32'h0000_0000.
- W1C: set `pending`=5'b10011, then store `io_write_data`=32'h0000_0200. The next load returns `pending` field 5'b10001.
- Collision: force a `stable` rise on `button[4]` on the same edge as a `BTN_ADDR` load. That load returns `pending[4]`=0, and the next load returns 32'h0000_1010 while the button is held.
- Decode: a load from 12'h074 returns 0; a store to `SW_ADDR` changes nothing; a load with `io_en`=0 returns 0 and does not clear `pending`.
